// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive stream.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Clock cycles per bit (integer division).
  function automatic int unsigned uart_div(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte stream from the UART receiver to its consumer, plus error pulses.
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overflow;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overflow,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overflow,
    output ready
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rdata while non-empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A push into a full FIFO is still accepted if the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Hold the last shown byte while empty so the output never goes X.
  assign rdata = empty ? hold_q : mem[rptr_q[AW-1:0]];

  // Pointer and output-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      hold_q <= rdata;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver: synchronizer, bit-recovery FSM and show-ahead output FIFO.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned FREQ  = 100000000,
  parameter int unsigned BAUD  = 115200,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              cpu_reset_n,
  input  logic              rx,
  uart_rx_stream_if.master  strm
);

  localparam int unsigned DIV  = uart_div(FREQ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

  logic                 rx_m, rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bidx_q, bidx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 push;
  logic                 ferr_d, ferr_q;
  logic                 ovf_d, ovf_q;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchronizer; reset to the idle line level.
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM, counters, shift register and registered error pulses.
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: sample at mid-bit, start check at HALF then every DIV cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bidx_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d        = '0;
          sh_d[bidx_q] = rx_s;
          if (bidx_q == 3'd7) state_d = STOP;
          else                bidx_d  = bidx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        // Stay here until the line returns high so a held-low line is not a new start.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte is dropped only when full and the head is not leaving this cycle.
  always_comb begin
    ovf_d = push && fifo_full && !(strm.ready && !fifo_empty);
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (cpu_reset_n),
    .push  (push),
    .wdata (sh_d),
    .pop   (strm.ready),
    .rdata (strm.data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign strm.valid     = !fifo_empty;
  assign strm.frame_err = ferr_q;
  assign strm.overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench: drives 8N1 frames on rx and scoreboards the output stream.
module tb_uart_rx_stream;

  localparam int unsigned FREQ  = 3200000;
  localparam int unsigned BAUD  = 100000;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV   = FREQ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  // Start drive to valid: 2 sync flops, 1 idle detect, HALF to start sample, 9 bits to stop.
  localparam int LAT = 3 + HALF + 9 * DIV;

  logic clk = 1'b0;
  logic cpu_reset_n;
  logic rx;
  logic ready_val;
  logic rand_mode;
  logic rand_bit;

  uart_rx_stream_if strm_if ();
  assign strm_if.ready = rand_mode ? rand_bit : ready_val;

  uart_rx_stream #(
    .FREQ  (FREQ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .cpu_reset_n (cpu_reset_n),
    .rx          (rx),
    .strm        (strm_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  int valid_hi  = 0;
  int ferr_cnt  = 0;
  int ovf_cnt   = 0;
  logic [7:0] rise_data = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q [$];
  event started;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1 rand_bit = ($urandom_range(0, 3) != 0);
  end

  // Compare process: scoreboard every accepted byte, hold data while empty, count pulses.
  always @(negedge clk) begin
    if (!cpu_reset_n) begin
      last_data  = 8'h00;
      prev_valid = 1'b0;
    end else begin
      if (strm_if.frame_err) ferr_cnt++;
      if (strm_if.overflow)  ovf_cnt++;
      if (strm_if.valid) valid_hi++;
      if (strm_if.valid && !prev_valid) begin
        rise_cyc  = cyc;
        rise_data = strm_if.data;
      end
      if (strm_if.valid && strm_if.ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h expected no byte", strm_if.data);
        end else begin
          check("stream_data", {24'h0, strm_if.data}, {24'h0, exp_q.pop_front()});
        end
      end else if (!strm_if.valid) begin
        check("data_hold", {24'h0, strm_if.data}, {24'h0, last_data});
      end
      last_data  = strm_if.data;
      prev_valid = strm_if.valid;
    end
  end

  task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low);
    @(posedge clk);
    #1 rx = 1'b0;
    start_cyc = cyc;
    -> started;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    #1 rx = stop_ok;
    repeat (DIV) @(posedge clk);
    if (hold_low > 0) begin
      #1 rx = 1'b0;
      repeat (hold_low) @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || strm_if.valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid_low"}, {31'h0, strm_if.valid}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0;
    logic [7:0] b;
    cpu_reset_n = 1'b0;
    rx          = 1'b1;
    ready_val   = 1'b0;
    rand_mode   = 1'b0;
    #1;
    check("reset_valid", {31'h0, strm_if.valid}, 0);
    check("reset_data", {24'h0, strm_if.data}, 0);
    check("reset_ferr", {31'h0, strm_if.frame_err}, 0);
    check("reset_ovf", {31'h0, strm_if.overflow}, 0);
    repeat (5) @(posedge clk);
    #1 cpu_reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single byte, ready high; latency and one-cycle valid.
    ready_val = 1'b1;
    f0 = ferr_cnt;
    valid_hi = 0;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 0);
    drain("t1");
    check("t1_latency", rise_cyc - start_cyc, LAT);
    check("t1_latency_literal", rise_cyc - start_cyc, 307);
    check("t1_rise_data", {24'h0, rise_data}, 32'h55);
    check("t1_valid_cycles", valid_hi, 1);
    check("t1_ferr", ferr_cnt - f0, 0);

    // 2: short low glitch is rejected, then a clean byte.
    f0 = ferr_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    #1;
    check("t2_glitch_valid", {31'h0, strm_if.valid}, 0);
    check("t2_glitch_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 0);
    drain("t2");

    // 3: bad stop bit then a long break, then a clean byte.
    f0 = ferr_cnt;
    send(8'hA5, 1'b0, 3000);
    check("t3_ferr", ferr_cnt - f0, 1);
    check("t3_valid", {31'h0, strm_if.valid}, 0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 0);
    drain("t3");
    check("t3_ferr_total", ferr_cnt - f0, 1);

    // 4: fill with ready low, fifth byte overflows.
    ready_val = 1'b0;
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 0);
    end
    #1;
    check("t4_valid_full", {31'h0, strm_if.valid}, 1);
    check("t4_ovf", ovf_cnt - o0, 1);
    ready_val = 1'b1;
    drain("t4");

    // 5: full FIFO, ready raised exactly on the push cycle of the next byte.
    ready_val = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'h11 * 8'(i + 1);
      exp_q.push_back(b);
      send(b, 1'b1, 0);
    end
    exp_q.push_back(8'h5A);
    fork
      send(8'h5A, 1'b1, 0);
      begin
        @(started);
        while (cyc < start_cyc + LAT - 1) begin
          @(posedge clk);
          #1;
        end
        ready_val = 1'b1;
      end
    join
    drain("t5");
    check("t5_ovf", ovf_cnt - o0, 0);

    // 6: reset in the middle of a frame with a byte pending.
    ready_val = 1'b0;
    exp_q.push_back(8'h77);
    send(8'h77, 1'b1, 0);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (DIV) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1 cpu_reset_n = 1'b0;
    #1;
    check("t6_valid", {31'h0, strm_if.valid}, 0);
    check("t6_data", {24'h0, strm_if.data}, 0);
    check("t6_ferr", {31'h0, strm_if.frame_err}, 0);
    check("t6_ovf", {31'h0, strm_if.overflow}, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 cpu_reset_n = 1'b1;
    repeat (DIV) @(posedge clk);
    ready_val = 1'b1;
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, 0);
    drain("t6");

    // Random bytes with random backpressure.
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    rand_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b, 1'b1, 0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    rand_mode = 1'b0;
    ready_val = 1'b1;
    drain("rand");
    check("rand_ferr", ferr_cnt - f0, 0);
    check("rand_ovf", ovf_cnt - o0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
